bcfg_register_file: RTL and testbench



---
 rtl/bcfg_pkg.sv | 41 ++++
 rtl/bcfg_register_file_if.sv | 36 +++
 rtl/bcfg_register_file_cfg_reg16.sv | 39 +++
 rtl/bcfg_register_file.sv | 55 +++++
 tb/tb_bcfg_register_file.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bcfg_pkg.sv
// Shared constants for the convolution-layer base-configuration registers:
// field positions and widths, default reset values, and the shift-join helper.
package bcfg_pkg;

    localparam int unsigned RegW = 32'd16;

    localparam int unsigned EngineCountLsb = 32'd0;
    localparam int unsigned EngineCountMsb = 32'd11;
    localparam int unsigned EngineCountW   = 32'd12;

    localparam int unsigned ShiftLowLsb = 32'd12;
    localparam int unsigned ShiftLowMsb = 32'd15;
    localparam int unsigned ShiftLowW   = 32'd4;

    localparam int unsigned MatrixSizeLsb = 32'd0;
    localparam int unsigned MatrixSizeMsb = 32'd13;
    localparam int unsigned MatrixSizeW   = 32'd14;

    localparam int unsigned ShiftHighLsb = 32'd14;
    localparam int unsigned ShiftHighMsb = 32'd15;
    localparam int unsigned ShiftHighW   = 32'd2;

    localparam int unsigned ShiftFinalLsb = 32'd0;
    localparam int unsigned ShiftFinalMsb = 32'd5;
    localparam int unsigned ShiftFinalW   = 32'd6;

    localparam int unsigned ShiftAmountW = ShiftHighW + ShiftLowW;

    localparam logic [RegW-1:0] Bcfg1Default = 16'h0001;
    localparam logic [RegW-1:0] Bcfg2Default = 16'h0000;
    localparam logic [RegW-1:0] Bcfg3Default = 16'h0000;

    // The accumulate shift is split across two registers; high bits sit on top.
    function automatic logic [ShiftAmountW-1:0] join_shift(
        input logic [ShiftHighW-1:0] high,
        input logic [ShiftLowW-1:0]  low
    );
        return {high, low};
    endfunction

endpackage

// File: rtl/bcfg_register_file_if.sv
// Host write bus and decoded-field read bus of the base-configuration registers.
interface bcfg_register_file_if;
    import bcfg_pkg::*;

    logic [RegW-1:0]         bcfg1_data_i;
    logic                    bcfg1_we_i;
    logic [RegW-1:0]         bcfg2_data_i;
    logic                    bcfg2_we_i;
    logic [RegW-1:0]         bcfg3_data_i;
    logic                    bcfg3_we_i;

    logic [RegW-1:0]         bcfg1_o;
    logic [RegW-1:0]         bcfg2_o;
    logic [RegW-1:0]         bcfg3_o;
    logic [EngineCountW-1:0] engine_count_o;
    logic [ShiftLowW-1:0]    shift_low_o;
    logic [MatrixSizeW-1:0]  matrix_size_o;
    logic [ShiftHighW-1:0]   shift_high_o;
    logic [ShiftAmountW-1:0] shift_amount_o;
    logic [ShiftFinalW-1:0]  shift_final_o;

    modport master (
        output bcfg1_data_i, bcfg1_we_i, bcfg2_data_i, bcfg2_we_i,
               bcfg3_data_i, bcfg3_we_i,
        input  bcfg1_o, bcfg2_o, bcfg3_o, engine_count_o, shift_low_o,
               matrix_size_o, shift_high_o, shift_amount_o, shift_final_o
    );

    modport slave (
        input  bcfg1_data_i, bcfg1_we_i, bcfg2_data_i, bcfg2_we_i,
               bcfg3_data_i, bcfg3_we_i,
        output bcfg1_o, bcfg2_o, bcfg3_o, engine_count_o, shift_low_o,
               matrix_size_o, shift_high_o, shift_amount_o, shift_final_o
    );

endinterface

// File: rtl/bcfg_register_file_cfg_reg16.sv
// 16-bit configuration register with write enable and a parameterised
// value that an asynchronous active-low reset restores.
module cfg_reg16
    import bcfg_pkg::*;
#(
    parameter logic [RegW-1:0] ResetVal = 16'h0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [RegW-1:0] data_i,
    output logic [RegW-1:0] data_o
);

    logic [RegW-1:0] data_d;
    logic [RegW-1:0] data_q;

    // Next value: load on write enable, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (we_i) begin
            data_d = data_i;
        end else begin
            data_d = data_q;
        end
    end

    // Storage; reset overrides any pending write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q <= ResetVal;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bcfg_register_file.sv
// Three base-configuration registers for the convolution layer, with their
// named fields sliced out for the engines, counters and output shifters.
module bcfg_register_file
    import bcfg_pkg::*;
#(
    parameter logic [RegW-1:0] Bcfg1Reset = Bcfg1Default,
    parameter logic [RegW-1:0] Bcfg2Reset = Bcfg2Default,
    parameter logic [RegW-1:0] Bcfg3Reset = Bcfg3Default
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    bcfg_register_file_if.slave  bus
);

    logic [RegW-1:0] bcfg1_s;
    logic [RegW-1:0] bcfg2_s;
    logic [RegW-1:0] bcfg3_s;

    cfg_reg16 #(.ResetVal(Bcfg1Reset)) u_bcfg1 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (bus.bcfg1_we_i),
        .data_i (bus.bcfg1_data_i),
        .data_o (bcfg1_s)
    );

    cfg_reg16 #(.ResetVal(Bcfg2Reset)) u_bcfg2 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (bus.bcfg2_we_i),
        .data_i (bus.bcfg2_data_i),
        .data_o (bcfg2_s)
    );

    cfg_reg16 #(.ResetVal(Bcfg3Reset)) u_bcfg3 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (bus.bcfg3_we_i),
        .data_i (bus.bcfg3_data_i),
        .data_o (bcfg3_s)
    );

    // Values are passed through unchecked; consumers validate ranges.
    assign bus.bcfg1_o        = bcfg1_s;
    assign bus.bcfg2_o        = bcfg2_s;
    assign bus.bcfg3_o        = bcfg3_s;
    assign bus.engine_count_o = bcfg1_s[EngineCountMsb:EngineCountLsb];
    assign bus.shift_low_o    = bcfg1_s[ShiftLowMsb:ShiftLowLsb];
    assign bus.matrix_size_o  = bcfg2_s[MatrixSizeMsb:MatrixSizeLsb];
    assign bus.shift_high_o   = bcfg2_s[ShiftHighMsb:ShiftHighLsb];
    assign bus.shift_amount_o = join_shift(bcfg2_s[ShiftHighMsb:ShiftHighLsb],
                                           bcfg1_s[ShiftLowMsb:ShiftLowLsb]);
    assign bus.shift_final_o  = bcfg3_s[ShiftFinalMsb:ShiftFinalLsb];

endmodule

// File: tb/tb_bcfg_register_file.sv
// Directed-vector bench for bcfg_register_file: reset defaults, field decode,
// hold behaviour, back-to-back writes and asynchronous reset priority.
module tb_bcfg_register_file;

    logic clk_i;
    logic rst_i;
    int   tests_run;
    int   tests_failed;

    bcfg_register_file_if bus ();

    bcfg_register_file dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic idle_inputs();
        bus.bcfg1_we_i   = 1'b0;
        bus.bcfg2_we_i   = 1'b0;
        bus.bcfg3_we_i   = 1'b0;
        bus.bcfg1_data_i = 16'h0000;
        bus.bcfg2_data_i = 16'h0000;
        bus.bcfg3_data_i = 16'h0000;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        tests_run++;
        if (bus.bcfg1_o !== 16'h0001) begin
            tests_failed++;
            $display("FAIL reset_bcfg1 actual=%h expected=0001", bus.bcfg1_o);
        end
        tests_run++;
        if (bus.engine_count_o !== 12'd1) begin
            tests_failed++;
            $display("FAIL reset_engine_count actual=%0d expected=1", bus.engine_count_o);
        end
        tests_run++;
        if (bus.bcfg2_o !== 16'h0000 || bus.bcfg3_o !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_bcfg23 actual=%h/%h expected=0000/0000", bus.bcfg2_o, bus.bcfg3_o);
        end
        tests_run++;
        if (bus.shift_amount_o !== 6'd0 || bus.matrix_size_o !== 14'd0 || bus.shift_final_o !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_fields actual=amt %0d mat %0d fin %0d expected=0 0 0",
                     bus.shift_amount_o, bus.matrix_size_o, bus.shift_final_o);
        end
    endtask

    task automatic test_dual_write();
        @(negedge clk_i);
        bus.bcfg1_data_i = 16'h0002; bus.bcfg1_we_i = 1'b1;
        bus.bcfg2_data_i = 16'h0005; bus.bcfg2_we_i = 1'b1;
        bus.bcfg3_data_i = 16'hABCD; bus.bcfg3_we_i = 1'b0;
        @(posedge clk_i);
        #1;
        idle_inputs();
        tests_run++;
        if (bus.engine_count_o !== 12'd2 || bus.shift_low_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL dual_bcfg1 actual=ec %0d sl %0d expected=ec 2 sl 0",
                     bus.engine_count_o, bus.shift_low_o);
        end
        tests_run++;
        if (bus.matrix_size_o !== 14'd5 || bus.shift_amount_o !== 6'd0) begin
            tests_failed++;
            $display("FAIL dual_bcfg2 actual=mat %0d amt %0d expected=mat 5 amt 0",
                     bus.matrix_size_o, bus.shift_amount_o);
        end
        tests_run++;
        if (bus.bcfg3_o !== 16'h0000) begin
            tests_failed++;
            $display("FAIL dual_bcfg3_unchanged actual=%h expected=0000", bus.bcfg3_o);
        end
    endtask

    task automatic test_max_fields();
        @(negedge clk_i);
        bus.bcfg1_data_i = 16'hF3FF; bus.bcfg1_we_i = 1'b1;
        bus.bcfg2_data_i = 16'hC00A; bus.bcfg2_we_i = 1'b1;
        @(posedge clk_i);
        #1;
        idle_inputs();
        tests_run++;
        if (bus.engine_count_o !== 12'd1023 || bus.shift_low_o !== 4'd15) begin
            tests_failed++;
            $display("FAIL max_bcfg1 actual=ec %0d sl %0d expected=ec 1023 sl 15",
                     bus.engine_count_o, bus.shift_low_o);
        end
        tests_run++;
        if (bus.shift_high_o !== 2'd3 || bus.matrix_size_o !== 14'd10) begin
            tests_failed++;
            $display("FAIL max_bcfg2 actual=sh %0d mat %0d expected=sh 3 mat 10",
                     bus.shift_high_o, bus.matrix_size_o);
        end
        tests_run++;
        if (bus.shift_amount_o !== 6'd63) begin
            tests_failed++;
            $display("FAIL max_shift_amount actual=%0d expected=63", bus.shift_amount_o);
        end
    endtask

    task automatic test_reserved();
        @(negedge clk_i);
        bus.bcfg3_data_i = 16'hFFC5; bus.bcfg3_we_i = 1'b1;
        @(posedge clk_i);
        #1;
        idle_inputs();
        tests_run++;
        if (bus.shift_final_o !== 6'd5 || bus.bcfg3_o !== 16'hFFC5) begin
            tests_failed++;
            $display("FAIL reserved_bcfg3 actual=fin %0d raw %h expected=fin 5 raw ffc5",
                     bus.shift_final_o, bus.bcfg3_o);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        bus.bcfg2_data_i = 16'h1111; bus.bcfg2_we_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus.bcfg2_data_i = 16'h6222;
        tests_run++;
        if (bus.bcfg2_o !== 16'h1111 || bus.matrix_size_o !== 14'h1111) begin
            tests_failed++;
            $display("FAIL b2b_first actual=raw %h mat %h expected=raw 1111 mat 1111",
                     bus.bcfg2_o, bus.matrix_size_o);
        end
        @(posedge clk_i);
        #1;
        idle_inputs();
        tests_run++;
        if (bus.bcfg2_o !== 16'h6222 || bus.shift_high_o !== 2'd1 || bus.shift_amount_o !== 6'd31) begin
            tests_failed++;
            $display("FAIL b2b_second actual=raw %h sh %0d amt %0d expected=raw 6222 sh 1 amt 31",
                     bus.bcfg2_o, bus.shift_high_o, bus.shift_amount_o);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            bus.bcfg1_data_i = 16'h1357 + 16'(i);
            bus.bcfg2_data_i = 16'h9BDF ^ 16'(i);
            bus.bcfg3_data_i = 16'h0F0F << (i % 4);
            @(posedge clk_i);
            #1;
            tests_run++;
            if (bus.bcfg1_o !== 16'hF3FF || bus.bcfg2_o !== 16'h6222 || bus.bcfg3_o !== 16'hFFC5) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d actual=%h/%h/%h expected=f3ff/6222/ffc5",
                         i, bus.bcfg1_o, bus.bcfg2_o, bus.bcfg3_o);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        @(posedge clk_i);
        #2;
        bus.bcfg1_data_i = 16'h1234; bus.bcfg1_we_i = 1'b1;
        rst_i = 1'b0;
        #1;
        tests_run++;
        if (bus.bcfg1_o !== 16'h0001 || bus.bcfg2_o !== 16'h0000 || bus.bcfg3_o !== 16'h0000) begin
            tests_failed++;
            $display("FAIL async_reset_immediate actual=%h/%h/%h expected=0001/0000/0000",
                     bus.bcfg1_o, bus.bcfg2_o, bus.bcfg3_o);
        end
        @(posedge clk_i);
        #1;
        tests_run++;
        if (bus.bcfg1_o !== 16'h0001 || bus.engine_count_o !== 12'd1) begin
            tests_failed++;
            $display("FAIL async_reset_write_lost actual=%h expected=0001", bus.bcfg1_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        bus.bcfg1_data_i = 16'h2007;
        @(posedge clk_i);
        #1;
        idle_inputs();
        tests_run++;
        if (bus.engine_count_o !== 12'd7 || bus.shift_low_o !== 4'd2 || bus.shift_amount_o !== 6'd2) begin
            tests_failed++;
            $display("FAIL first_write_after_reset actual=ec %0d sl %0d amt %0d expected=ec 7 sl 2 amt 2",
                     bus.engine_count_o, bus.shift_low_o, bus.shift_amount_o);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_i        = 1'b0;
        idle_inputs();
        test_reset();
        test_dual_write();
        test_max_fields();
        test_reserved();
        test_back_to_back();
        test_hold();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
